// File: rtl/ula32_vector_writer.sv
// ula32 test-vector generator: captures ALU requests, evaluates them on ula32 and
// streams {a, b, ALUcontrol, Result, ALUflags} records out of a first-word-fall-through FIFO.

module ula32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  alu_control,
  output logic [31:0] result,
  output logic [3:0]  alu_flags
);
  logic [31:0] b_eff;
  logic [32:0] sum;
  logic        carry;
  logic        overflow;

  always_comb begin
    // Subtraction is a + ~b + 1, sharing the adder with addition
    b_eff    = alu_control[0] ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {32'd0, alu_control[0]};
    result   = sum[31:0];
    carry    = sum[32];
    overflow = (a[31] == b_eff[31]) && (sum[31] != a[31]);
    if (alu_control[1]) begin
      result   = alu_control[0] ? (a | b) : (a & b);
      carry    = 1'b0;
      overflow = 1'b0;
    end
    alu_flags = {result[31], (result == 32'd0), carry, overflow};
  end
endmodule

module ula32_vector_writer #(
  parameter int DEPTH       = 8,
  parameter int MAX_VECTORS = 10001
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_a,
  input  logic [31:0]  in_b,
  input  logic [1:0]   in_ctrl,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [101:0] out_record,
  output logic [13:0]  vec_count,
  output logic         done
);
  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW+1:0]   DEPTH_L = (AW+2)'(DEPTH);
  localparam logic [13:0]     MAX_L   = 14'(MAX_VECTORS);

  logic          stage_valid_reg;
  logic [31:0]   stage_a_reg;
  logic [31:0]   stage_b_reg;
  logic [1:0]    stage_ctrl_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   fifo_count_reg;
  logic [AW:0]   fifo_count_next;
  logic [13:0]   vec_count_reg;
  logic [101:0]  mem [DEPTH];

  logic [31:0]   alu_result;
  logic [3:0]    alu_flags;
  logic [101:0]  stage_record;
  logic [AW+1:0] occupancy;
  logic          accept;
  logic          push;
  logic          pop;

  ula32 u_ula32 (
    .a           (stage_a_reg),
    .b           (stage_b_reg),
    .alu_control (stage_ctrl_reg),
    .result      (alu_result),
    .alu_flags   (alu_flags)
  );

  assign stage_record = {stage_a_reg, stage_b_reg, stage_ctrl_reg, alu_result, alu_flags};

  // Occupancy counts the capture stage too, so a captured request always has a FIFO slot
  assign occupancy = {1'b0, fifo_count_reg} + {{(AW+1){1'b0}}, stage_valid_reg};
  assign done      = (vec_count_reg == MAX_L);
  assign in_ready  = !done && (occupancy < DEPTH_L);
  assign out_valid = (fifo_count_reg != '0);
  assign out_record = out_valid ? mem[rd_ptr_reg] : '0;
  assign vec_count = vec_count_reg;

  assign accept = in_valid && in_ready;
  assign push   = stage_valid_reg;
  assign pop    = out_valid && out_ready;

  always_comb begin
    fifo_count_next = fifo_count_reg;
    if (push && !pop) begin
      fifo_count_next = fifo_count_reg + 1'b1;
    end else if (pop && !push) begin
      fifo_count_next = fifo_count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= stage_record;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid_reg <= 1'b0;
      stage_a_reg     <= '0;
      stage_b_reg     <= '0;
      stage_ctrl_reg  <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      fifo_count_reg  <= '0;
      vec_count_reg   <= '0;
    end else begin
      stage_valid_reg <= accept;
      if (accept) begin
        stage_a_reg    <= in_a;
        stage_b_reg    <= in_b;
        stage_ctrl_reg <= in_ctrl;
        vec_count_reg  <= vec_count_reg + 1'b1;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      fifo_count_reg <= fifo_count_next;
    end
  end
endmodule

// File: tb/tb_ula32_vector_writer.sv
// Bench for ula32_vector_writer: queue-based reference model checked every cycle on the
// main instance, directed literal checks, and a second instance with a 4-vector limit.

module tb_ula32_vector_writer;
  localparam int DEPTH  = 8;
  localparam int MAXV   = 10001;
  localparam int MAXV_L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, in_ready, out_valid, out_ready, done;
  logic [31:0]  in_a, in_b;
  logic [1:0]   in_ctrl;
  logic [101:0] out_record;
  logic [13:0]  vec_count;

  logic         l_reset, l_in_valid, l_in_ready, l_out_valid, l_out_ready, l_done;
  logic [31:0]  l_in_a, l_in_b;
  logic [1:0]   l_in_ctrl;
  logic [101:0] l_out_record;
  logic [13:0]  l_vec_count;

  int checks = 0;
  int errors = 0;

  ula32_vector_writer #(.DEPTH(DEPTH), .MAX_VECTORS(MAXV)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .out_valid(out_valid),
    .out_ready(out_ready), .out_record(out_record), .vec_count(vec_count), .done(done)
  );

  ula32_vector_writer #(.DEPTH(DEPTH), .MAX_VECTORS(MAXV_L)) dut_lim (
    .clk(clk), .reset(l_reset), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_a(l_in_a), .in_b(l_in_b), .in_ctrl(l_in_ctrl), .out_valid(l_out_valid),
    .out_ready(l_out_ready), .out_record(l_out_record), .vec_count(l_vec_count), .done(l_done)
  );

  task automatic chk(input string name, input logic [101:0] act, input logic [101:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ALU using wide integer arithmetic instead of an adder/flag circuit
  function automatic logic [101:0] model_rec(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op);
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint sa = $signed(a);
    longint sb = $signed(b);
    longint ideal;
    logic [31:0] r;
    logic c, v;
    case (op)
      2'b00: begin r = a + b; c = (ua + ub) > 64'hFFFF_FFFF; ideal = sa + sb; end
      2'b01: begin r = a - b; c = (ua >= ub); ideal = sa - sb; end
      2'b10: begin r = a & b; c = 1'b0; ideal = $signed(r); end
      default: begin r = a | b; c = 1'b0; ideal = $signed(r); end
    endcase
    v = (ideal != longint'($signed(r)));
    return {a, b, op, r, r[31], (r == 32'd0), c, v};
  endfunction

  typedef struct {
    logic [101:0] rec;
    int           acc;
  } ent_t;

  ent_t q[$];
  int   cyc = 0;
  int   m_vcount = 0;
  bit   m_armed = 0;
  int   acc_cnt = 0, pop_cnt = 0, first_pop = -1, last_pop = -1;

  // Model: every accepted request is pending until popped; visible two cycles after acceptance
  always @(negedge clk) begin : model
    bit           e_ready, e_ovalid;
    ent_t         e;
    e_ready  = (m_vcount != MAXV) && (q.size() < DEPTH);
    e_ovalid = (q.size() > 0) && (cyc - q[0].acc >= 2);
    if (m_armed && !reset) begin
      chk("in_ready", in_ready, e_ready);
      chk("out_valid", out_valid, e_ovalid);
      chk("vec_count", vec_count, m_vcount);
      chk("done", done, m_vcount == MAXV);
      if (e_ovalid) chk("out_record", out_record, q[0].rec);
    end
    if (!reset) begin
      if (in_valid && in_ready) acc_cnt++;
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
    end
    if (reset) begin
      q.delete();
      m_vcount = 0;
      m_armed  = 1;
    end else if (m_armed) begin
      if (e_ovalid && out_ready) void'(q.pop_front());
      if (in_valid && e_ready) begin
        e.rec = model_rec(in_a, in_b, in_ctrl);
        e.acc = cyc;
        q.push_back(e);
        m_vcount++;
      end
    end
    cyc++;
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      output int lat, output logic [101:0] rec);
    int k;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_ctrl = op;
    k = 0;
    do begin @(negedge clk); k++; end while (!in_ready && k < 50);
    chk("send_ready_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    rec = out_record;
    $display("send a=%h b=%h ctrl=%b latency=%0d record=%h", a, b, op, lat, rec);
  endtask

  initial begin
    int lat, base_acc, base_pop, l_acc, l_pops;
    logic [101:0] rec;

    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_ctrl = 2'b00;
    l_reset = 1'b1; l_in_valid = 1'b0; l_out_ready = 1'b0;
    l_in_a = 32'd0; l_in_b = 32'd1; l_in_ctrl = 2'b00;

    // Reset held two cycles with a request offered
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_vec_count", vec_count, 14'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_out_record", out_record, 102'd0);
    repeat (4) @(posedge clk);
    chk("rst_no_record", pop_cnt, 0);

    send(32'h0000_0001, 32'hFFFF_FFFF, 2'b00, lat, rec);
    chk("add_latency", lat, 2);
    chk("add_record", rec, {32'h0000_0001, 32'hFFFF_FFFF, 2'b00, 32'h0000_0000, 4'b0110});
    chk("add_vec_count", vec_count, 14'd1);

    send(32'h8000_0000, 32'h0000_0001, 2'b01, lat, rec);
    chk("sub_latency", lat, 2);
    chk("sub_record", rec, {32'h8000_0000, 32'h0000_0001, 2'b01, 32'h7FFF_FFFF, 4'b0011});

    send(32'hF0F0_F0F0, 32'hFF00_FF00, 2'b10, lat, rec);
    chk("and_record", rec, {32'hF0F0_F0F0, 32'hFF00_FF00, 2'b10, 32'hF000_F000, 4'b1000});

    // Backpressure: consumer stalled, producer keeps offering
    @(posedge clk); #1;
    out_ready = 1'b0;
    base_acc = acc_cnt; base_pop = pop_cnt;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      in_a = 32'h1000 + acc_cnt;
      in_b = 32'hFFFF_0000 - acc_cnt;
      in_ctrl = 2'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepts", acc_cnt - base_acc, DEPTH);
    chk("bp_in_ready_low", in_ready, 1'b0);
    $display("backpressure accepts=%0d in_ready=%b", acc_cnt - base_acc, in_ready);
    out_ready = 1'b1;
    repeat (12) @(posedge clk); #1;
    chk("bp_drained", pop_cnt - base_pop, DEPTH);

    // Streaming at one per cycle
    base_acc = acc_cnt; base_pop = pop_cnt; first_pop = -1;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_a = 32'h5000 + i; in_b = 32'h7; in_ctrl = 2'b00;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("stream_accepts", acc_cnt - base_acc, 20);
    chk("stream_pops", pop_cnt - base_pop, 20);
    chk("stream_no_gaps", last_pop - first_pop, 19);
    $display("stream accepts=%0d pops=%0d span=%0d", acc_cnt - base_acc, pop_cnt - base_pop,
             last_pop - first_pop);

    // Vector limit on the 4-vector instance
    @(posedge clk); #1;
    l_reset = 1'b0; l_out_ready = 1'b1;
    l_acc = 0; l_pops = 0;
    for (int i = 0; i < 12; i++) begin
      l_in_valid = (i < 6);
      l_in_a = 32'h100 + l_acc;
      @(negedge clk);
      if (l_out_valid) begin
        chk("lim_record", l_out_record, model_rec(32'h100 + l_pops, 32'd1, 2'b00));
        l_pops++;
      end
      if (l_in_valid && l_in_ready) l_acc++;
      @(posedge clk); #1;
    end
    l_in_valid = 1'b0;
    chk("lim_accepts", l_acc, MAXV_L);
    chk("lim_pops", l_pops, MAXV_L);
    chk("lim_done", l_done, 1'b1);
    chk("lim_in_ready", l_in_ready, 1'b0);
    chk("lim_vec_count", l_vec_count, 14'(MAXV_L));
    $display("limit accepts=%0d pops=%0d done=%b", l_acc, l_pops, l_done);

    // Refill to the limit with the consumer stalled, drain two, then reset
    l_reset = 1'b1;
    @(posedge clk); #1;
    l_reset = 1'b0; l_out_ready = 1'b0; l_in_valid = 1'b1;
    repeat (6) @(posedge clk); #1;
    l_in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    l_out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    l_out_ready = 1'b0;
    chk("lim_buffered", l_out_valid, 1'b1);
    l_reset = 1'b1;
    @(posedge clk); #1;
    l_reset = 1'b0; l_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("lim_discarded", l_out_valid, 1'b0);
    end
    chk("lim_rst_done", l_done, 1'b0);
    chk("lim_rst_vec_count", l_vec_count, 14'd0);
    $display("limit reset done=%b vec_count=%0d", l_done, l_vec_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/ula32_vector_writer.md
# ula32_vector_writer

Hardware generator for ula32 test vectors. It accepts ALU operation requests over a valid/ready handshake and evaluates each one on an internal ula32 instance. Each result is packed into a 102-bit record with the same layout the ula32 bench reads from TBVectors: {a, b, ALUcontrol, Result, ALUflags}. Records are buffered in a FIFO and streamed out over a second valid/ready port to a capture or dump path.

## Interface
- DEPTH, 8: record FIFO depth. Must be a power of 2, at least 2.
- MAX_VECTORS, 10001: number of vectors accepted before the block stops. This matches the bench vector memory [10000:0].
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset. Sampled on the rising edge of clk.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- in_a  in  32  operand a.
- in_b  in  32  operand b.
- in_ctrl  in  2  ALUcontrol: 00 add, 01 sub, 10 and, 11 or.
- out_valid  out  1  FIFO head record valid.
- out_ready  in  1  consumer takes the head record this cycle.
- out_record  out  102  bit layout: [101:70] a, [69:38] b, [37:36] ALUcontrol, [35:4] Result, [3:0] ALUflags {N,Z,C,V}.
- vec_count  out  14  number of requests accepted since reset.
- done  out  1  high when vec_count == MAX_VECTORS.

## Operation
- **Accept.** A request is accepted when in_valid && in_ready at a rising edge.
- **Capture stage.** On accept, in_a, in_b and in_ctrl are registered into the capture stage, and stage_valid is set.
- **ALU evaluation.** The ula32 instance is driven combinationally from the capture stage.
  - add: Result = a + b.
  - sub: Result = a + ~b + 1.
  - and / or: bitwise.
  - N = Result[31]; Z = (Result == 0).
  - add/sub: C = carry-out of the 33-bit sum; V = signed overflow.
  - and/or: C = 0, V = 0.
- **Push.** When stage_valid is set, the record is written into the FIFO on the next edge.
- **Pipelining.** If a new request is accepted on that same edge, the capture stage reloads. There is no bubble.
- **FIFO.** First-word-fall-through:
  - out_record presents the head entry.
  - A pop occurs on out_valid && out_ready.
  - Order is strictly preserved.
- **in_ready** = !done && (fifo_count + stage_valid < DEPTH).
  - It is computed from registered state only.
  - A pop in the same cycle does not raise in_ready.
- **Full FIFO.** The FIFO can never overflow. There is no drop and no error path.
- **Counter.** vec_count increments on each accept and stops at MAX_VECTORS.
- **Done.** When done = 1:
  - in_ready stays 0.
  - Records still in the pipeline and FIFO continue to drain.
  - done stays 1 until reset.
- **Simultaneous push and pop** with a non-empty FIFO: fifo_count is unchanged, and both pointers advance.
- **Pointer wrap-around.** Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. fifo_count is log2(DEPTH)+1 bits.
- **Undefined operands.** Operands are not checked. X/Z inputs are captured as-is.

## Timing
- **Reset values** (one edge with reset = 1):
  - out_valid = 0, in_ready = 1, vec_count = 0, done = 0.
  - stage_valid = 0, fifo_count = 0, pointers = 0.
  - out_record = 0.
- **Reset priority.** Reset overrides all other activity on the same edge.
- **Reset mid-operation.** The pending capture stage and all FIFO contents are discarded. Nothing is emitted afterwards.
- **Latency.** A request accepted at the edge ending cycle t:
  - is in the capture stage during t+1;
  - is written to the FIFO at the end of t+1;
  - gives out_valid = 1 with its record in cycle t+2, if it is ahead of nothing.
- **Throughput.** One request per cycle is sustained when out_ready is held at 1.
- **Stable head.** out_record and out_valid change only at rising edges. The head record is stable while out_valid && !out_ready.
- **Input handshake.** in_ready does not depend on in_valid, so there is no combinational path from in_valid.

## Test plan
1. **Reset.** Assert reset for 2 cycles with in_valid = 1 → out_valid = 0, in_ready = 1, vec_count = 0, done = 0. No record appears afterwards.
2. **Add, carry and zero.** a = 0x00000001, b = 0xFFFFFFFF, ctrl = 00, accepted at cycle t → out_valid first high in t+2. Record has Result = 0x00000000, flags = 0110. vec_count = 1.
3. **Sub, overflow.** a = 0x80000000, b = 0x00000001, ctrl = 01 → Result = 0x7FFFFFFF, flags = 0011. Then and: a = 0xF0F0F0F0, b = 0xFF00FF00, ctrl = 10 → Result = 0xF000F000, flags = 1000.
4. **Backpressure.** Hold out_ready = 0 and in_valid = 1 with distinct operands → exactly DEPTH = 8 accepts, then in_ready = 0 and stays 0. Raise out_ready → 8 records come out in input order, head stable while stalled, and in_ready returns to 1 one cycle after the first pop.
5. **Streaming.** Hold in_valid = out_ready = 1 for 20 cycles with an incrementing a → 20 records at one per cycle after the 2-cycle latency. No gaps and no duplicates; pointers wrap twice.
6. **Limit and reset.** With MAX_VECTORS = 4, offer 6 requests → 4 accepted, done = 1, in_ready = 0 after the 4th, and all 4 records drain. Then assert reset while 2 records are still buffered → both are discarded, done = 0 and vec_count = 0.
